// File: rtl/can_frame_tx_pkg.sv
// Shared CAN definitions: controller states, CRC15 polynomial, field widths
// and small helpers used by both the transmitter and the receiver.
package can_frame_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BUS_WAIT,
        S_STUFFED,
        S_CRC_DEL,
        S_ACK_SLOT,
        S_ACK_DEL,
        S_EOF,
        S_IFS
    } can_state_e;

    localparam logic [14:0] CAN_CRC_POLY  = 15'h4599;
    localparam int          CAN_BASE_ID_W = 11;
    localparam int          CAN_EXT_ID_W  = 18;
    localparam int          CAN_DLC_W     = 4;
    localparam int          CAN_CRC_W     = 15;

    localparam int CAN_FRAME_W     = 127;
    localparam int CAN_BASE_HDR    = 19;  // SOF .. DLC, base format
    localparam int CAN_EXT_HDR     = 39;  // SOF .. DLC, extended format
    localparam int CAN_BASE_ARB    = 12;  // index of RTR, base format
    localparam int CAN_EXT_ARB     = 32;  // index of RTR, extended format
    localparam int CAN_STUFF_LIMIT = 5;
    localparam int CAN_IDLE_BITS   = 11;
    localparam int CAN_EOF_BITS    = 7;

    function automatic logic [CAN_CRC_W-1:0] can_crc15_step(
        input logic [CAN_CRC_W-1:0] crc,
        input logic                 din
    );
        logic                 fb;
        logic [CAN_CRC_W-1:0] nxt;
        fb  = din ^ crc[CAN_CRC_W-1];
        nxt = {crc[CAN_CRC_W-2:0], 1'b0};
        if (fb) begin
            nxt = nxt ^ CAN_CRC_POLY;
        end
        return nxt;
    endfunction

    function automatic logic [3:0] can_payload_bytes(
        input logic [CAN_DLC_W-1:0] dlc,
        input logic                 rtr
    );
        if (rtr) begin
            return 4'd0;
        end
        return (dlc > 4'd8) ? 4'd8 : dlc;
    endfunction

endpackage

// File: rtl/can_stuff_crc_tx.sv
// Run-length tracker for bit stuffing plus the running CRC15 of the
// transmitted (unstuffed) frame bits; CRC can also be shifted out MSB first.
module can_stuff_crc_tx
(
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic step,
    input  logic bit_in,
    input  logic crc_en,
    input  logic crc_shift,
    output logic stuff_due,
    output logic stuff_bit,
    output logic crc_msb
);
    import can_frame_tx_pkg::*;

    logic [2:0]           run_q,  run_d;
    logic                 last_q, last_d;
    logic [CAN_CRC_W-1:0] crc_q,  crc_d;

    always_comb begin
        run_d  = run_q;
        last_d = last_q;
        crc_d  = crc_q;
        if (clr) begin
            run_d  = 3'd0;
            last_d = 1'b1;
            crc_d  = '0;
        end else if (step) begin
            // Stuff bits restart the run, so they take part in the next count.
            if (run_q != 3'd0 && bit_in == last_q) begin
                run_d = run_q + 3'd1;
            end else begin
                run_d = 3'd1;
            end
            last_d = bit_in;
            if (crc_en) begin
                crc_d = can_crc15_step(crc_q, bit_in);
            end else if (crc_shift) begin
                crc_d = {crc_q[CAN_CRC_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run_q  <= 3'd0;
            last_q <= 1'b1;
            crc_q  <= '0;
        end else begin
            run_q  <= run_d;
            last_q <= last_d;
            crc_q  <= crc_d;
        end
    end

    assign stuff_due = (run_q == 3'(CAN_STUFF_LIMIT));
    assign stuff_bit = ~last_q;
    assign crc_msb   = crc_q[CAN_CRC_W-1];

endmodule

// File: rtl/can_frame_tx.sv
// CAN 2.0A/B frame transmitter: one frame per accepted request, with bus-idle
// wait, arbitration, stuffing, CRC15, ACK handling, EOF and intermission.
module can_frame_tx #(
    parameter int IFS_BITS = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        bit_req,
    input  logic        bit_rx,
    output logic        bit_tx,
    input  logic        tx_start,
    input  logic        tx_ide,
    input  logic        tx_rtr,
    input  logic [28:0] tx_id,
    input  logic [3:0]  tx_dlc,
    input  logic [63:0] tx_data,
    output logic        tx_ready,
    output logic        tx_done,
    output logic        tx_acked,
    output logic        tx_arb_lost,
    output logic        tx_err
);
    import can_frame_tx_pkg::*;

    localparam logic [3:0] IFS_LAST = 4'(IFS_BITS - 1);

    can_state_e             state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   bit_tx_q, bit_tx_d;
    logic                   ready_q, ready_d;
    logic                   done_q, done_d;
    logic                   acked_q, acked_d;
    logic                   arb_q, arb_d;
    logic                   err_q, err_d;
    logic                   ack_q, ack_d;
    logic [CAN_FRAME_W-1:0] frame_q, frame_d;
    logic [6:0]             idx_q, idx_d;
    logic                   stuffed_q, stuffed_d;
    logic                   ide_q, ide_d;
    logic [6:0]             crc_start_q, crc_start_d;
    logic [6:0]             last_idx_q, last_idx_d;

    logic       sc_clr, sc_step, sc_bit, sc_crc_en, sc_crc_shift;
    logic       stuff_due, stuff_bit, crc_msb;
    logic [6:0] next_idx, arb_end;
    logic       in_arb;
    logic [3:0] nbytes;

    function automatic logic [CAN_FRAME_W-1:0] assemble(
        input logic        ide,
        input logic        rtr,
        input logic [28:0] id,
        input logic [3:0]  dlc,
        input logic [63:0] data
    );
        if (ide) begin
            return {1'b0, id[28:18], 1'b1, 1'b1, id[17:0], rtr, 2'b00, dlc, data, 24'd0};
        end
        return {1'b0, id[10:0], rtr, 2'b00, dlc, data, 44'd0};
    endfunction

    can_stuff_crc_tx u_stuff_crc (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (sc_clr),
        .step      (sc_step),
        .bit_in    (sc_bit),
        .crc_en    (sc_crc_en),
        .crc_shift (sc_crc_shift),
        .stuff_due (stuff_due),
        .stuff_bit (stuff_bit),
        .crc_msb   (crc_msb)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_tx_d     = bit_tx_q;
        done_d       = 1'b0;
        acked_d      = 1'b0;
        arb_d        = 1'b0;
        err_d        = 1'b0;
        ack_d        = ack_q;
        frame_d      = frame_q;
        idx_d        = idx_q;
        stuffed_d    = stuffed_q;
        ide_d        = ide_q;
        crc_start_d  = crc_start_q;
        last_idx_d   = last_idx_q;
        sc_clr       = 1'b0;
        sc_step      = 1'b0;
        sc_bit       = 1'b1;
        sc_crc_en    = 1'b0;
        sc_crc_shift = 1'b0;
        next_idx     = idx_q + 7'd1;
        nbytes       = can_payload_bytes(tx_dlc, tx_rtr);
        arb_end      = ide_q ? 7'(CAN_EXT_ARB) : 7'(CAN_BASE_ARB);
        // A stuff bit following RTR already belongs to the control field.
        in_arb       = (idx_q != 7'd0) &&
                       (stuffed_q ? (idx_q < arb_end) : (idx_q <= arb_end));

        case (state_q)
            S_IDLE: begin
                bit_tx_d = 1'b1;
                if (ready_q && tx_start) begin
                    frame_d     = assemble(tx_ide, tx_rtr, tx_id, tx_dlc, tx_data);
                    ide_d       = tx_ide;
                    crc_start_d = (tx_ide ? 7'(CAN_EXT_HDR) : 7'(CAN_BASE_HDR)) + {nbytes, 3'b000};
                    last_idx_d  = crc_start_d + 7'(CAN_CRC_W - 1);
                    idx_d       = 7'd0;
                    stuffed_d   = 1'b0;
                    cnt_d       = 4'd0;
                    sc_clr      = 1'b1;
                    state_d     = S_BUS_WAIT;
                end
            end
            S_BUS_WAIT: begin
                if (bit_req) begin
                    if (!bit_rx) begin
                        cnt_d = 4'd0;
                    end else if (cnt_q == 4'(CAN_IDLE_BITS - 1)) begin
                        sc_step   = 1'b1;
                        sc_bit    = frame_q[CAN_FRAME_W-1];
                        sc_crc_en = 1'b1;
                        bit_tx_d  = sc_bit;
                        frame_d   = frame_q << 1;
                        idx_d     = 7'd0;
                        stuffed_d = 1'b0;
                        state_d   = S_STUFFED;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            S_STUFFED: begin
                if (bit_req) begin
                    if (bit_rx != bit_tx_q) begin
                        bit_tx_d = 1'b1;
                        state_d  = S_IDLE;
                        if (in_arb && bit_tx_q && !bit_rx) begin
                            arb_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (stuff_due) begin
                        sc_step   = 1'b1;
                        sc_bit    = stuff_bit;
                        bit_tx_d  = sc_bit;
                        stuffed_d = 1'b1;
                    end else if (idx_q == last_idx_q) begin
                        bit_tx_d = 1'b1;
                        state_d  = S_CRC_DEL;
                    end else begin
                        sc_step   = 1'b1;
                        idx_d     = next_idx;
                        stuffed_d = 1'b0;
                        if (next_idx < crc_start_q) begin
                            sc_bit    = frame_q[CAN_FRAME_W-1];
                            sc_crc_en = 1'b1;
                            frame_d   = frame_q << 1;
                        end else begin
                            sc_bit       = crc_msb;
                            sc_crc_shift = 1'b1;
                        end
                        bit_tx_d = sc_bit;
                    end
                end
            end
            S_CRC_DEL: begin
                if (bit_req) begin
                    bit_tx_d = 1'b1;
                    if (!bit_rx) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_ACK_SLOT;
                    end
                end
            end
            S_ACK_SLOT: begin
                if (bit_req) begin
                    bit_tx_d = 1'b1;
                    ack_d    = ~bit_rx;
                    state_d  = S_ACK_DEL;
                end
            end
            S_ACK_DEL: begin
                if (bit_req) begin
                    bit_tx_d = 1'b1;
                    if (bit_rx) begin
                        done_d  = 1'b1;
                        acked_d = ack_q;
                        cnt_d   = 4'd0;
                        state_d = S_EOF;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_EOF: begin
                if (bit_req) begin
                    bit_tx_d = 1'b1;
                    if (cnt_q == 4'(CAN_EOF_BITS - 1)) begin
                        cnt_d   = 4'd0;
                        state_d = (IFS_BITS == 0) ? S_IDLE : S_IFS;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            S_IFS: begin
                if (bit_req) begin
                    bit_tx_d = 1'b1;
                    if (cnt_q == IFS_LAST) begin
                        cnt_d   = 4'd0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                bit_tx_d = 1'b1;
                state_d  = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            bit_tx_q    <= 1'b1;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            acked_q     <= 1'b0;
            arb_q       <= 1'b0;
            err_q       <= 1'b0;
            ack_q       <= 1'b0;
            frame_q     <= '0;
            idx_q       <= 7'd0;
            stuffed_q   <= 1'b0;
            ide_q       <= 1'b0;
            crc_start_q <= 7'd0;
            last_idx_q  <= 7'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_tx_q    <= bit_tx_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            acked_q     <= acked_d;
            arb_q       <= arb_d;
            err_q       <= err_d;
            ack_q       <= ack_d;
            frame_q     <= frame_d;
            idx_q       <= idx_d;
            stuffed_q   <= stuffed_d;
            ide_q       <= ide_d;
            crc_start_q <= crc_start_d;
            last_idx_q  <= last_idx_d;
        end
    end

    assign bit_tx      = bit_tx_q;
    assign tx_ready    = ready_q;
    assign tx_done     = done_q;
    assign tx_acked    = acked_q;
    assign tx_arb_lost = arb_q;
    assign tx_err      = err_q;

endmodule

// File: tb/tb_can_frame_tx.sv
// Directed bench for can_frame_tx: loopback bus with ACK injection, expected
// stuffed bit stream queued per frame and popped as the DUT emits each bit.
module tb_can_frame_tx;

    logic        clk = 1'b0;
    logic        rstn;
    logic        bit_req;
    logic        bit_rx;
    logic        bit_tx;
    logic        tx_start;
    logic        tx_ide;
    logic        tx_rtr;
    logic [28:0] tx_id;
    logic [3:0]  tx_dlc;
    logic [63:0] tx_data;
    logic        tx_ready;
    logic        tx_done;
    logic        tx_acked;
    logic        tx_arb_lost;
    logic        tx_err;

    int total = 0;
    int bad   = 0;
    int n_done = 0, n_err = 0, n_arb = 0;
    int d0, e0, a0;
    int pos;

    logic sb_q[$];
    int   map_pos[$];
    logic obs_bits[$];

    always #5 clk = ~clk;

    can_frame_tx #(.IFS_BITS(3)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .bit_req     (bit_req),
        .bit_rx      (bit_rx),
        .bit_tx      (bit_tx),
        .tx_start    (tx_start),
        .tx_ide      (tx_ide),
        .tx_rtr      (tx_rtr),
        .tx_id       (tx_id),
        .tx_dlc      (tx_dlc),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .tx_done     (tx_done),
        .tx_acked    (tx_acked),
        .tx_arb_lost (tx_arb_lost),
        .tx_err      (tx_err)
    );

    always @(negedge clk) begin
        if (tx_done === 1'b1)     n_done++;
        if (tx_err === 1'b1)      n_err++;
        if (tx_arb_lost === 1'b1) n_arb++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_bit(input logic rx);
        @(negedge clk);
        bit_rx  = rx;
        bit_req = 1'b1;
        @(negedge clk);
        bit_req = 1'b0;
    endtask

    // Reference frame: raw fields, CRC15 over SOF..data, then stuffing.
    task automatic build_model(input logic ide, input logic rtr, input logic [28:0] id,
                               input logic [3:0] dlc, input logic [63:0] data);
        logic        raw[$];
        logic [14:0] crc;
        logic        fb;
        logic        prev;
        int          run;
        int          nb;
        sb_q.delete();
        map_pos.delete();
        raw.push_back(1'b0);
        if (ide) begin
            for (int i = 28; i >= 18; i--) raw.push_back(id[i]);
            raw.push_back(1'b1);
            raw.push_back(1'b1);
            for (int i = 17; i >= 0; i--) raw.push_back(id[i]);
            raw.push_back(rtr);
            raw.push_back(1'b0);
            raw.push_back(1'b0);
        end else begin
            for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
            raw.push_back(rtr);
            raw.push_back(1'b0);
            raw.push_back(1'b0);
        end
        for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
        nb = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
        for (int i = 0; i < nb * 8; i++) raw.push_back(data[63 - i]);
        crc = 15'd0;
        foreach (raw[i]) begin
            fb  = raw[i] ^ crc[14];
            crc = {crc[13:0], 1'b0};
            if (fb) crc = crc ^ 15'h4599;
        end
        for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
        prev = 1'b1;
        run  = 0;
        foreach (raw[i]) begin
            map_pos.push_back(sb_q.size());
            sb_q.push_back(raw[i]);
            if (run != 0 && raw[i] == prev) run++;
            else run = 1;
            prev = raw[i];
            if (run == 5) begin
                sb_q.push_back(~raw[i]);
                prev = ~raw[i];
                run  = 1;
            end
        end
    endtask

    task automatic submit(input logic ide, input logic rtr, input logic [28:0] id,
                          input logic [3:0] dlc, input logic [63:0] data);
        int guard;
        guard = 0;
        @(negedge clk);
        while (tx_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_start", tx_ready, 1);
        build_model(ide, rtr, id, dlc, data);
        obs_bits.delete();
        d0 = n_done; e0 = n_err; a0 = n_arb;
        tx_ide = ide; tx_rtr = rtr; tx_id = id; tx_dlc = dlc; tx_data = data;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_ide = ~ide; tx_rtr = ~rtr; tx_id = ~id; tx_dlc = ~dlc; tx_data = ~data;
        check("ready_after_start", tx_ready, 0);
    endtask

    task automatic pop_cmp();
        logic e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            obs_bits.push_back(bit_tx);
            check($sformatf("stream_bit%0d", pos), bit_tx, e);
        end
    endtask

    task automatic reach_sof(input bit poke);
        for (int i = 0; i < 11; i++) begin
            if (poke && i == 5) begin
                tx_start = 1'b1; tx_ide = 1'b1; tx_id = 29'h0; tx_dlc = 4'hF;
                @(negedge clk);
                tx_start = 1'b0;
                check("ready_in_bus_wait", tx_ready, 0);
            end
            do_bit(1'b1);
            if (i < 10) check("bus_wait_recessive", bit_tx, 1);
        end
        pos = 0;
        pop_cmp();
    endtask

    task automatic play_until(input int stop);
        while (sb_q.size() > 0 && pos < stop) begin
            do_bit(bit_tx);
            pos++;
            pop_cmp();
        end
    endtask

    task automatic finish_frame(input logic ack_dom, input logic exp_acked);
        play_until(1000);
        do_bit(bit_tx);
        check("crc_delim", bit_tx, 1);
        do_bit(1'b1);
        check("ack_slot_drive", bit_tx, 1);
        do_bit(ack_dom ? 1'b0 : 1'b1);
        check("ack_delim_drive", bit_tx, 1);
        check("done_early", tx_done, 0);
        do_bit(1'b1);
        check("tx_done", tx_done, 1);
        check("tx_acked", tx_acked, exp_acked);
        for (int i = 0; i < 10; i++) begin
            do_bit(1'b1);
            check("eof_ifs_recessive", bit_tx, 1);
            if (i == 8) check("ready_in_ifs", tx_ready, 0);
        end
        check("ready_after_ifs", tx_ready, 1);
        check("done_count", n_done - d0, 1);
        check("err_count", n_err - e0, 0);
        check("arb_count", n_arb - a0, 0);
    endtask

    initial begin
        logic [5:0] pre;
        logic       ds[$];
        logic       prev;
        logic       skip;
        logic [3:0] dlc_f;
        int         run;

        rstn = 1'b0; bit_req = 1'b0; bit_rx = 1'b1; tx_start = 1'b0;
        tx_ide = 1'b0; tx_rtr = 1'b0; tx_id = '0; tx_dlc = '0; tx_data = '0;
        repeat (3) @(negedge clk);
        check("rst_bit_tx", bit_tx, 1);
        check("rst_ready", tx_ready, 0);
        check("rst_done", tx_done, 0);
        check("rst_acked", tx_acked, 0);
        check("rst_arb", tx_arb_lost, 0);
        check("rst_err", tx_err, 0);
        rstn = 1'b1;
        #1;
        check("ready_before_first_clk", tx_ready, 0);
        @(negedge clk);
        check("ready_after_reset", tx_ready, 1);

        // Base 0x456, two data bytes, acknowledged
        submit(1'b0, 1'b0, 29'h456, 4'd2, 64'hA55A_0000_0000_0000);
        reach_sof(1'b0);
        finish_frame(1'b1, 1'b1);

        // All-dominant header forces an early stuff bit; ACK slot left recessive
        submit(1'b0, 1'b0, 29'h000, 4'd0, 64'h0);
        reach_sof(1'b0);
        finish_frame(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) pre[5 - i] = obs_bits[i];
        check("sof_stuff_prefix", pre, 6'b000001);

        // Extended frame, DLC 15 carries 8 bytes
        submit(1'b1, 1'b0, 29'h1ABCDEF0, 4'd15, 64'h0123_4567_89AB_CDEF);
        reach_sof(1'b0);
        finish_frame(1'b1, 1'b1);
        prev = 1'b1; run = 0; skip = 1'b0;
        foreach (obs_bits[i]) begin
            if (skip) begin
                skip = 1'b0;
                prev = obs_bits[i];
                run  = 1;
            end else begin
                ds.push_back(obs_bits[i]);
                if (run != 0 && obs_bits[i] == prev) run++;
                else run = 1;
                prev = obs_bits[i];
                if (run == 5) skip = 1'b1;
            end
        end
        check("ext_destuffed_len", ds.size(), 118);
        dlc_f = '0;
        if (ds.size() > 38) dlc_f = {ds[35], ds[36], ds[37], ds[38]};
        check("ext_dlc_field", dlc_f, 4'b1111);

        // Remote frame: data field omitted even with nonzero DLC
        submit(1'b0, 1'b1, 29'h555, 4'd3, 64'hFFFF_0000_0000_0000);
        reach_sof(1'b0);
        finish_frame(1'b1, 1'b1);

        // Arbitration lost at ID[3] of base 0x7FF
        submit(1'b0, 1'b0, 29'h7FF, 4'd1, 64'hFF00_0000_0000_0000);
        reach_sof(1'b0);
        play_until(map_pos[8]);
        do_bit(1'b0);
        check("arb_lost_pulse", tx_arb_lost, 1);
        check("arb_no_err", tx_err, 0);
        check("arb_release", bit_tx, 1);
        check("arb_ready", tx_ready, 1);
        for (int i = 0; i < 12; i++) begin
            do_bit(1'($urandom_range(0, 1)));
            check("arb_bus_released", bit_tx, 1);
        end
        check("arb_count", n_arb - a0, 1);
        check("arb_err_count", n_err - e0, 0);
        check("arb_done_count", n_done - d0, 0);

        // Recessive readback on a dominant DLC bit; start during BUS_WAIT dropped
        submit(1'b0, 1'b0, 29'h123, 4'd4, 64'h1234_5678_0000_0000);
        reach_sof(1'b1);
        play_until(map_pos[15]);
        do_bit(1'b1);
        check("bit_err_pulse", tx_err, 1);
        check("bit_err_no_arb", tx_arb_lost, 0);
        check("bit_err_release", bit_tx, 1);
        check("bit_err_ready", tx_ready, 1);
        for (int i = 0; i < 15; i++) begin
            do_bit(bit_tx);
            check("no_restart_after_err", bit_tx, 1);
        end
        check("err_count", n_err - e0, 1);
        check("err_done_count", n_done - d0, 0);

        // Reset in the data field, then a clean frame
        submit(1'b0, 1'b0, 29'h2AA, 4'd8, 64'h0F12_3456_789A_BCDE);
        reach_sof(1'b0);
        play_until(map_pos[21]);
        check("pre_reset_dominant", bit_tx, 0);
        #2;
        rstn = 1'b0;
        #1;
        check("reset_release_bus", bit_tx, 1);
        repeat (2) @(negedge clk);
        check("reset_ready_low", tx_ready, 0);
        check("reset_no_err", n_err - e0, 0);
        check("reset_no_arb", n_arb - a0, 0);
        check("reset_no_done", n_done - d0, 0);
        rstn = 1'b1;
        @(negedge clk);
        check("ready_after_midframe_reset", tx_ready, 1);
        submit(1'b0, 1'b0, 29'h2AA, 4'd8, 64'h0F12_3456_789A_BCDE);
        reach_sof(1'b0);
        finish_frame(1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
